// File: rtl/btn_conditioner.sv
// Button input conditioner: 2-flop synchroniser, polarity normalisation,
// press/release debounce and hold-to-auto-repeat. One instance per button.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 262,
    parameter int unsigned HOLD_CYCLES     = 16384,
    parameter int unsigned REPEAT_CYCLES   = 6554,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic btn_raw,
    output logic step,
    output logic held,
    output logic repeating,
    output logic released
);

    localparam logic             INACTIVE     = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StDebPress,
        StPressed,
        StRepeat,
        StDebRelease
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sync2;
    logic             p;

    // Synchroniser keeps running while disabled so p is valid on re-enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= INACTIVE;
            sync2 <= INACTIVE;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Active-high pressed level regardless of pad polarity.
    assign p = sync2 ^ INACTIVE;

    // Debounce / auto-repeat FSM with registered outputs; cnt clears on every state change.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state     <= StIdle;
            cnt       <= '0;
            step      <= 1'b0;
            held      <= 1'b0;
            repeating <= 1'b0;
            released  <= 1'b0;
        end else begin
            step     <= 1'b0;
            released <= 1'b0;
            case (state)
                StIdle: begin
                    if (p) begin
                        state <= StDebPress;
                        cnt   <= '0;
                    end
                end
                StDebPress: begin
                    if (!p) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= StPressed;
                        cnt   <= '0;
                        step  <= 1'b1;
                        held  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StPressed: begin
                    if (!p) begin
                        state <= StDebRelease;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state     <= StRepeat;
                        cnt       <= '0;
                        step      <= 1'b1;
                        repeating <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StRepeat: begin
                    if (!p) begin
                        state     <= StDebRelease;
                        cnt       <= '0;
                        repeating <= 1'b0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt  <= '0;
                        step <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StDebRelease: begin
                    // A bounce back to pressed restarts the hold timer without a step.
                    if (p) begin
                        state <= StPressed;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state    <= StIdle;
                        cnt      <= '0;
                        released <= 1'b1;
                        held     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= StIdle;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
